// File: rtl/dmem_lane_arbiter_pkg.sv
// Shared types and defaults for the dual-lane data-memory arbiter.
package dmem_lane_arbiter_pkg;

  localparam int unsigned D_WIDTH_DEF = 32;
  localparam int unsigned STALLCNT_W  = 16;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_SECOND = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_L0   = 2'd1,
    SEL_L1   = 2'd2
  } lane_sel_e;

endpackage

// File: rtl/dmem_lane_arbiter_if.sv
// Lane request / memory / result bundle between the mem stages and the arbiter.
interface dmem_lane_arbiter_if #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned CNT_W   = 16
);
  logic               i_Req0;
  logic               i_WE0;
  logic [D_WIDTH-1:0] i_Addr0;
  logic [D_WIDTH-1:0] i_WData0;
  logic               i_Req1;
  logic               i_WE1;
  logic [D_WIDTH-1:0] i_Addr1;
  logic [D_WIDTH-1:0] i_WData1;
  logic               i_Kill1;
  logic [D_WIDTH-1:0] o_MemAddr;
  logic [D_WIDTH-1:0] o_MemWData;
  logic               o_MemWE;
  logic [D_WIDTH-1:0] i_MemRD;
  logic [D_WIDTH-1:0] o_RD0;
  logic [D_WIDTH-1:0] o_RD1;
  logic               o_Stall;
  logic [CNT_W-1:0]   o_StallCnt;

  // Arbiter side
  modport slave (
    input  i_Req0, i_WE0, i_Addr0, i_WData0,
    input  i_Req1, i_WE1, i_Addr1, i_WData1, i_Kill1,
    input  i_MemRD,
    output o_MemAddr, o_MemWData, o_MemWE,
    output o_RD0, o_RD1, o_Stall, o_StallCnt
  );

  // Pipeline + memory side
  modport master (
    output i_Req0, i_WE0, i_Addr0, i_WData0,
    output i_Req1, i_WE1, i_Addr1, i_WData1, i_Kill1,
    output i_MemRD,
    input  o_MemAddr, o_MemWData, o_MemWE,
    input  o_RD0, o_RD1, o_Stall, o_StallCnt
  );
endinterface

// File: rtl/dmem_lane_arbiter_arb_mux.sv
// Lane-select mux feeding address, write data and write enable to data memory.
module dmem_lane_arbiter_arb_mux
  import dmem_lane_arbiter_pkg::*;
#(
  parameter int unsigned D_WIDTH = D_WIDTH_DEF
) (
  input  lane_sel_e          sel_i,
  input  logic [D_WIDTH-1:0] addr0_i,
  input  logic [D_WIDTH-1:0] wdata0_i,
  input  logic               we0_i,
  input  logic [D_WIDTH-1:0] addr1_i,
  input  logic [D_WIDTH-1:0] wdata1_i,
  input  logic               we1_i,
  output logic [D_WIDTH-1:0] mem_addr_o,
  output logic [D_WIDTH-1:0] mem_wdata_o,
  output logic               mem_we_o
);

  // Route the granted lane; no grant drives an idle, non-writing port
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    case (sel_i)
      SEL_L0: begin
        mem_addr_o  = addr0_i;
        mem_wdata_o = wdata0_i;
        mem_we_o    = we0_i;
      end
      SEL_L1: begin
        mem_addr_o  = addr1_i;
        mem_wdata_o = wdata1_i;
        mem_we_o    = we1_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lane_arbiter.sv
// Serialises the two mem-stage lanes onto one data-memory port, older lane 0 first.
module dmem_lane_arbiter
  import dmem_lane_arbiter_pkg::*;
#(
  parameter int unsigned D_WIDTH     = D_WIDTH_DEF,
  parameter int unsigned CNT_W       = STALLCNT_W,
  parameter int unsigned MERGE_LOADS = 1
) (
  input logic                clk,
  input logic                rst_n,
  dmem_lane_arbiter_if.slave bus
);

  arb_state_e         st_q, st_d;
  logic [D_WIDTH-1:0] rd0_hold_q, rd0_hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               r0, r1, merge;
  lane_sel_e          sel;
  logic [D_WIDTH-1:0] rd0_c, rd1_c;
  logic               stall_c;
  logic               mux_we;

  // Effective requests; a killed lane 1 is invisible to the arbiter
  assign r0    = bus.i_Req0;
  assign r1    = bus.i_Req1 & ~bus.i_Kill1;
  assign merge = (MERGE_LOADS != 0) & ~bus.i_WE0 & ~bus.i_WE1 &
                 (bus.i_Addr0 == bus.i_Addr1);

  // State, held lane-0 load data and conflict counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ARB_IDLE;
      rd0_hold_q <= '0;
      cnt_q      <= '0;
    end else begin
      st_q       <= st_d;
      rd0_hold_q <= rd0_hold_d;
      cnt_q      <= cnt_d;
    end
  end

  // Grant selection, load-data return, stall and next state
  always_comb begin
    st_d       = st_q;
    rd0_hold_d = rd0_hold_q;
    cnt_d      = cnt_q;
    sel        = SEL_NONE;
    rd0_c      = '0;
    rd1_c      = '0;
    stall_c    = 1'b0;
    case (st_q)
      ARB_IDLE: begin
        if (r0 && r1) begin
          sel   = SEL_L0;
          rd0_c = bus.i_MemRD;
          if (merge) begin
            rd1_c = bus.i_MemRD;
          end else begin
            stall_c    = 1'b1;
            rd0_hold_d = bus.i_MemRD;
            st_d       = ARB_SECOND;
            cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          end
        end else if (r0) begin
          sel   = SEL_L0;
          rd0_c = bus.i_MemRD;
        end else if (r1) begin
          sel   = SEL_L1;
          rd1_c = bus.i_MemRD;
        end
      end
      ARB_SECOND: begin
        // Lane 0 already completed; its load data comes from the hold register
        rd0_c = rd0_hold_q;
        if (r1) begin
          sel   = SEL_L1;
          rd1_c = bus.i_MemRD;
        end
        st_d = ARB_IDLE;
      end
      default: st_d = ARB_IDLE;
    endcase
  end

  dmem_lane_arbiter_arb_mux #(
    .D_WIDTH (D_WIDTH)
  ) u_arb_mux (
    .sel_i       (sel),
    .addr0_i     (bus.i_Addr0),
    .wdata0_i    (bus.i_WData0),
    .we0_i       (bus.i_WE0),
    .addr1_i     (bus.i_Addr1),
    .wdata1_i    (bus.i_WData1),
    .we1_i       (bus.i_WE1),
    .mem_addr_o  (bus.o_MemAddr),
    .mem_wdata_o (bus.o_MemWData),
    .mem_we_o    (mux_we)
  );

  // Reset suppresses any write and releases the pipeline immediately
  assign bus.o_MemWE    = mux_we & rst_n;
  assign bus.o_Stall    = stall_c & rst_n;
  assign bus.o_RD0      = rd0_c;
  assign bus.o_RD1      = rd1_c;
  assign bus.o_StallCnt = cnt_q;

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Scoreboard bench: randomized lane pairs against a program-order memory model.
module tb_dmem_lane_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // sel picks the active DUT: 0 = merging, 16-bit counter; 1 = no merge, 2-bit counter
  bit          sel;
  logic        req0, we0, req1, we1, kill1;
  logic [7:0]  a0, a1;
  logic [31:0] d0, d1;

  dmem_lane_arbiter_if #(.D_WIDTH(32), .CNT_W(16)) ifa ();
  dmem_lane_arbiter_if #(.D_WIDTH(32), .CNT_W(2))  ifb ();

  dmem_lane_arbiter #(.D_WIDTH(32), .CNT_W(16), .MERGE_LOADS(1)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (ifa.slave));
  dmem_lane_arbiter #(.D_WIDTH(32), .CNT_W(2), .MERGE_LOADS(0)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (ifb.slave));

  assign ifa.i_Req0   = req0 & ~sel;
  assign ifa.i_WE0    = we0;
  assign ifa.i_Addr0  = 32'(a0);
  assign ifa.i_WData0 = d0;
  assign ifa.i_Req1   = req1 & ~sel;
  assign ifa.i_WE1    = we1;
  assign ifa.i_Addr1  = 32'(a1);
  assign ifa.i_WData1 = d1;
  assign ifa.i_Kill1  = kill1;

  assign ifb.i_Req0   = req0 & sel;
  assign ifb.i_WE0    = we0;
  assign ifb.i_Addr0  = 32'(a0);
  assign ifb.i_WData0 = d0;
  assign ifb.i_Req1   = req1 & sel;
  assign ifb.i_WE1    = we1;
  assign ifb.i_Addr1  = 32'(a1);
  assign ifb.i_WData1 = d1;
  assign ifb.i_Kill1  = kill1;

  // Data memories: combinational read, write on rising edge
  logic [31:0] mema [256];
  logic [31:0] memb [256];
  bit          mem_init_done = 1'b0;
  assign ifa.i_MemRD = mema[ifa.o_MemAddr[7:0]];
  assign ifb.i_MemRD = memb[ifb.o_MemAddr[7:0]];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) begin
        mema[i] <= 32'h0;
        memb[i] <= 32'h0;
      end
      mem_init_done <= 1'b1;
    end else begin
      if (ifa.o_MemWE) mema[ifa.o_MemAddr[7:0]] <= ifa.o_MemWData;
      if (ifb.o_MemWE) memb[ifb.o_MemAddr[7:0]] <= ifb.o_MemWData;
    end
  end

  logic        stall_o, we_o;
  logic [31:0] rd0_o, rd1_o, cnt_o;
  assign stall_o = sel ? ifb.o_Stall : ifa.o_Stall;
  assign we_o    = sel ? ifb.o_MemWE : ifa.o_MemWE;
  assign rd0_o   = sel ? ifb.o_RD0   : ifa.o_RD0;
  assign rd1_o   = sel ? ifb.o_RD1   : ifa.o_RD1;
  assign cnt_o   = sel ? 32'(ifb.o_StallCnt) : 32'(ifa.o_StallCnt);

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outcome of one issued lane pair
  typedef struct {
    bit          chk0;
    logic [31:0] rd0;
    bit          z0;
    bit          chk1;
    logic [31:0] rd1;
    bit          z1;
    int          stalls;
    int          cnt;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] refm [2][256];
  int          cntm [2];
  bit          active = 1'b0;
  bit          quiet  = 1'b1;
  int          retired = 0;
  int          stall_seen = 0;

  // Monitor: a pair retires on the first non-stalled cycle it is presented
  always @(negedge clk) begin
    if (rst_n && !quiet) begin
      if (active) begin
        if (stall_o) begin
          stall_seen++;
        end else if (exp_q.size() == 0) begin
          check("unexpected_retire", 64'(exp_q.size()), 64'd1);
        end else begin
          rec_t r;
          r = exp_q.pop_front();
          check("stall_cycles", 64'(stall_seen), 64'(r.stalls));
          if (r.chk0) check("rd0", 64'(rd0_o), 64'(r.rd0));
          if (r.z0)   check("rd0_idle", 64'(rd0_o), 64'd0);
          if (r.chk1) check("rd1", 64'(rd1_o), 64'(r.rd1));
          if (r.z1)   check("rd1_idle", 64'(rd1_o), 64'd0);
          check("stall_cnt", 64'(cnt_o), 64'(r.cnt));
          stall_seen = 0;
          retired++;
        end
      end else begin
        check("idle_stall", 64'(stall_o), 64'd0);
        check("idle_we", 64'(we_o), 64'd0);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 1'b0; we0 = 1'b0; a0 = 8'h0; d0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; a1 = 8'h0; d1 = 32'h0;
    kill1 = 1'b0;
  endtask

  // Issue one pair (called just after a rising edge); kl raises kill1 in the stall's second cycle
  task automatic issue(input bit q0, input bit w0, input logic [7:0] ad0, input logic [31:0] wd0,
                       input bit q1, input bit w1, input logic [7:0] ad1, input logic [31:0] wd1,
                       input bit k1, input bit kl);
    rec_t r;
    bit   r1, conflict, klate, l1;
    int   start, cmax;
    r1       = q1 && !k1;
    conflict = q0 && r1 && !(!sel && !w0 && !w1 && ad0 == ad1);
    klate    = kl && conflict;
    l1       = r1 && !klate;
    cmax     = sel ? 3 : 65535;
    // Program order: lane 0 completes before lane 1 touches memory
    r.chk0 = q0 && !w0;
    r.rd0  = refm[sel][ad0];
    r.z0   = !q0;
    if (q0 && w0) refm[sel][ad0] = wd0;
    r.chk1 = l1 && !w1;
    r.rd1  = refm[sel][ad1];
    r.z1   = !l1;
    if (l1 && w1) refm[sel][ad1] = wd1;
    if (conflict && cntm[sel] < cmax) cntm[sel]++;
    r.stalls = conflict ? 1 : 0;
    r.cnt    = cntm[sel];
    exp_q.push_back(r);
    req0 = q0; we0 = w0; a0 = ad0; d0 = wd0;
    req1 = q1; we1 = w1; a1 = ad1; d1 = wd1;
    kill1 = k1;
    start = retired;
    active = 1'b1;
    if (klate) begin
      next_cycle();
      kill1 = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if (retired != start) break;
    end
    check("retire", 64'(retired - start), 64'd1);
    active = 1'b0;
    clear_inputs();
  endtask

  task automatic random_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      issue($urandom_range(0, 3) != 0, 1'($urandom), 8'(8'h10 + $urandom_range(0, 3)), $urandom,
            $urandom_range(0, 3) != 0, 1'($urandom), 8'(8'h10 + $urandom_range(0, 3)), $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) next_cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 1'b0;
    clear_inputs();
    for (int s = 0; s < 2; s++) begin
      cntm[s] = 0;
      for (int i = 0; i < 256; i++) refm[s][i] = 32'h0;
    end
    #2;
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_we", 64'(we_o), 64'd0);
    check("rst_cnt", 64'(cnt_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet = 1'b0;

    // Single requests: store then load
    issue(1, 1, 8'h10, 32'hA5, 0, 0, 8'h0, 32'h0, 0, 0);
    issue(1, 0, 8'h10, 32'h0,  0, 0, 8'h0, 32'h0, 0, 0);
    // Lane-1-only load
    issue(0, 0, 8'h0,  32'h0,  1, 0, 8'h10, 32'h0, 0, 0);
    // Conflict: lane 0 store, lane 1 load same address
    issue(1, 1, 8'h20, 32'h11, 1, 0, 8'h20, 32'h0, 0, 0);
    // Load then store to the same address: lane 0 sees old data
    issue(1, 0, 8'h20, 32'h0,  1, 1, 8'h20, 32'h22, 0, 0);
    // Two stores, lane 1 wins
    issue(1, 1, 8'h24, 32'h3,  1, 1, 8'h24, 32'h4, 0, 0);
    issue(1, 0, 8'h24, 32'h0,  0, 0, 8'h0, 32'h0, 0, 0);
    // Merged loads
    issue(1, 1, 8'h30, 32'h77, 0, 0, 8'h0, 32'h0, 0, 0);
    issue(1, 0, 8'h30, 32'h0,  1, 0, 8'h30, 32'h0, 0, 0);
    // Store + load same address never merge
    issue(1, 0, 8'h30, 32'h0,  1, 1, 8'h30, 32'h78, 0, 0);
    // Kill in first cycle, and kill raised during the second cycle
    issue(1, 1, 8'h40, 32'h1,  1, 1, 8'h40, 32'h2, 1, 0);
    issue(1, 0, 8'h40, 32'h0,  0, 0, 8'h0, 32'h0, 0, 0);
    issue(1, 1, 8'h48, 32'h1,  1, 1, 8'h48, 32'h2, 0, 1);
    issue(1, 0, 8'h48, 32'h0,  0, 0, 8'h0, 32'h0, 0, 0);

    // Reset while lane 1's store is pending in the second cycle
    quiet = 1'b1;
    req0 = 1'b1; we0 = 1'b1; a0 = 8'h50; d0 = 32'h5;
    req1 = 1'b1; we1 = 1'b1; a1 = 8'h50; d1 = 32'h6;
    next_cycle();
    refm[0][8'h50] = 32'h5;
    check("pre_reset_cnt", 64'(cnt_o), 64'(cntm[0] + 1));
    rst_n = 1'b0;
    #1;
    check("mid_reset_stall", 64'(stall_o), 64'd0);
    check("mid_reset_we", 64'(we_o), 64'd0);
    check("mid_reset_cnt", 64'(cnt_o), 64'd0);
    next_cycle();
    clear_inputs();
    rst_n = 1'b1;
    cntm[0] = 0;
    quiet = 1'b0;
    next_cycle();
    issue(1, 0, 8'h50, 32'h0, 0, 0, 8'h0, 32'h0, 0, 0);

    random_pairs(150);

    // Non-merging, narrow-counter instance
    sel = 1'b1;
    next_cycle();
    issue(1, 1, 8'h30, 32'h77, 0, 0, 8'h0, 32'h0, 0, 0);
    issue(1, 0, 8'h30, 32'h0,  1, 0, 8'h30, 32'h0, 0, 0);
    for (int i = 0; i < 5; i++)
      issue(1, 1, 8'(8'h60 + i), 32'(i), 1, 0, 8'(8'h60 + i), 32'h0, 0, 0);
    check("sat_cnt", 64'(cnt_o), 64'd3);
    random_pairs(40);

    next_cycle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
